bomb_placer_ctrl: RTL

Sequencer that fills the Lab 4 minesweeper board with a requested number of unique bombs. It pulls 6-bit cell indices from the random-number source over a req/valid handshake, rejects duplicates and the protected first-click cell, and builds a 64-bit bomb map for the board/display logic. It sits between the game FSM (start/done) and the random generator, and owns the retry policy so the game never deadlocks on a bad random stream.

---
 rtl/bomb_placer_ctrl_if.sv | 18 +
 rtl/bomb_placer_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/bomb_placer_ctrl_if.sv
// Random-index handshake between the bomb placer (master) and the random source (slave).
interface bomb_placer_ctrl_if;
  logic       rand_req;
  logic       rand_valid;
  logic [5:0] rand_value;

  modport master (
    output rand_req,
    input  rand_valid,
    input  rand_value
  );

  modport slave (
    input  rand_req,
    output rand_valid,
    output rand_value
  );
endinterface

// File: rtl/bomb_placer_ctrl.sv
// bomb_placer_ctrl: fills the minesweeper board with a requested number of unique bombs.
// Indices come from the random source over the rand_req/rand_valid handshake. An index is
// rejected if it is already a bomb or is the protected first-click cell. A run of
// consecutive rejects ends the fill early with a sticky error, so a bad random stream
// can never hang the game.
module bomb_placer_ctrl #(
  parameter int MAX_BOMBS   = 40,
  parameter int MAX_RETRIES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [5:0]         num_bombs,
  input  logic               safe_en,
  input  logic [5:0]         safe_cell,
  bomb_placer_ctrl_if.master rnd,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [63:0]        bomb_map,
  output logic [5:0]         bombs_placed
);

  localparam logic [5:0] BOMB_CLAMP  = 6'(MAX_BOMBS);
  localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRIES);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CHECK,
    DONE
  } state_t;

  state_t     state;
  logic [5:0] target;
  logic       safe_en_q;
  logic [5:0] safe_cell_q;
  logic [5:0] idx_q;
  logic [7:0] retry_cnt;

  logic [5:0] clamped_target;
  logic       is_reject;
  logic [7:0] retry_next;
  logic [5:0] placed_next;

  // Limit the requested bomb count to what the board is allowed to hold.
  always_comb begin
    clamped_target = (num_bombs > BOMB_CLAMP) ? BOMB_CLAMP : num_bombs;
  end

  // Decide whether the captured index is usable and precompute the counter increments.
  always_comb begin
    is_reject   = bomb_map[idx_q] || (safe_en_q && (idx_q == safe_cell_q));
    retry_next  = retry_cnt + 8'd1;
    placed_next = bombs_placed + 6'd1;
  end

  // Placement sequencer; outputs are registered alongside the state so they are glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      target       <= '0;
      safe_en_q    <= 1'b0;
      safe_cell_q  <= '0;
      idx_q        <= '0;
      retry_cnt    <= '0;
      rnd.rand_req <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      bomb_map     <= '0;
      bombs_placed <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            target       <= clamped_target;
            safe_en_q    <= safe_en;
            safe_cell_q  <= safe_cell;
            bomb_map     <= '0;
            bombs_placed <= '0;
            retry_cnt    <= '0;
            error        <= 1'b0;
            if (clamped_target == 6'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state        <= REQ;
              rnd.rand_req <= 1'b1;
              busy         <= 1'b1;
            end
          end
        end

        REQ: begin
          if (rnd.rand_valid) begin
            idx_q        <= rnd.rand_value;
            rnd.rand_req <= 1'b0;
            state        <= CHECK;
          end
        end

        CHECK: begin
          if (is_reject) begin
            retry_cnt <= retry_next;
            if (retry_next == RETRY_LIMIT) begin
              error <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rnd.rand_req <= 1'b1;
              state        <= REQ;
            end
          end else begin
            bomb_map[idx_q] <= 1'b1;
            bombs_placed    <= placed_next;
            retry_cnt       <= '0;
            if (placed_next == target) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rnd.rand_req <= 1'b1;
              state        <= REQ;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state        <= IDLE;
          rnd.rand_req <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
